// File: rtl/wave_analyzer.sv
// rtl/wave_analyzer.sv - per-period period/max/min/peak-to-peak measurement with hysteresis crossing detector
module wave_analyzer #(
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 20,
  parameter int MID      = 128,
  parameter int HYST     = 8,
  parameter int TIMEOUT  = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample,
  output logic                meas_valid,
  output logic [PERIOD_W-1:0] meas_period,
  output logic [DATA_W-1:0]   meas_max,
  output logic [DATA_W-1:0]   meas_min,
  output logic [DATA_W-1:0]   meas_pp,
  output logic                locked,
  output logic                meas_timeout
);

  localparam logic [DATA_W-1:0]   TH_HI   = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0]   TH_LO   = DATA_W'(MID - HYST);
  localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {SEEK_LOW, SEEK_HIGH, MEAS_HIGH, MEAS_LOW} state_t;

  state_t              r_state, w_state;
  logic [PERIOD_W-1:0] r_cnt, w_cnt;
  logic [DATA_W-1:0]   r_max, w_max;
  logic [DATA_W-1:0]   r_min, w_min;
  logic                w_publish, w_timeout;

  logic                r_meas_valid, r_meas_timeout, r_locked;
  logic [PERIOD_W-1:0] r_meas_period;
  logic [DATA_W-1:0]   r_meas_max, r_meas_min, r_meas_pp;

  logic w_low, w_high, w_cross;
  assign w_low   = (sample <= TH_LO);
  assign w_high  = (sample >= TH_HI);
  // A rising crossing only counts once the signal has been seen low first.
  assign w_cross = w_high && ((r_state == SEEK_HIGH) || (r_state == MEAS_LOW));

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_max     = r_max;
    w_min     = r_min;
    w_publish = 1'b0;
    w_timeout = 1'b0;
    if (sample_valid) begin
      if (w_cross) begin
        w_publish = (r_state == MEAS_LOW);
        w_state   = MEAS_HIGH;
        w_cnt     = PERIOD_W'(1);
        w_max     = sample;
        w_min     = sample;
      end else if (r_cnt == TO_LAST) begin
        w_timeout = 1'b1;
        w_state   = SEEK_LOW;
        w_cnt     = '0;
        w_max     = '0;
        w_min     = '1;
      end else begin
        w_cnt = r_cnt + PERIOD_W'(1);
        case (r_state)
          SEEK_LOW: begin
            if (w_low) w_state = SEEK_HIGH;
          end
          MEAS_HIGH, MEAS_LOW: begin
            if (sample > r_max) w_max = sample;
            if (sample < r_min) w_min = sample;
            if (r_state == MEAS_HIGH && w_low) w_state = MEAS_LOW;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEEK_LOW;
      r_cnt   <= '0;
      r_max   <= '0;
      r_min   <= '1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_max   <= w_max;
      r_min   <= w_min;
    end
  end

  // Results are captured from the pre-crossing running values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_valid   <= 1'b0;
      r_meas_timeout <= 1'b0;
      r_meas_period  <= '0;
      r_meas_max     <= '0;
      r_meas_min     <= '0;
      r_meas_pp      <= '0;
      r_locked       <= 1'b0;
    end else begin
      r_meas_valid   <= w_publish;
      r_meas_timeout <= w_timeout;
      if (w_publish) begin
        r_meas_period <= r_cnt;
        r_meas_max    <= r_max;
        r_meas_min    <= r_min;
        r_meas_pp     <= r_max - r_min;
        r_locked      <= 1'b1;
      end else if (w_timeout) begin
        r_meas_period <= '0;
        r_locked      <= 1'b0;
      end
    end
  end

  assign meas_valid   = r_meas_valid;
  assign meas_timeout = r_meas_timeout;
  assign meas_period  = r_meas_period;
  assign meas_max     = r_meas_max;
  assign meas_min     = r_meas_min;
  assign meas_pp      = r_meas_pp;
  assign locked       = r_locked;

endmodule
